// File: rtl/cmp_lgez_seq.sv
// Chunk-serial less/greater/equal-zero comparator, MSB chunk first with early exit.
// Optional signed compare via `define CMP_LGEZ_SEQ_SIGNED_EN (adds i_signed port).
module cmp_lgez_seq #(
  parameter int p_WIDTH = 16,
  parameter int p_CHUNK = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_valid,
  output logic               i_ready,
  input  logic [p_WIDTH-1:0] i_x,
  input  logic [p_WIDTH-1:0] i_y,
`ifdef CMP_LGEZ_SEQ_SIGNED_EN
  input  logic               i_signed,
`endif
  output logic               o_valid,
  input  logic               o_ready,
  output logic [1:0]         o_res,
  output logic               o_busy
);

  localparam int NCHUNK = (p_WIDTH + p_CHUNK - 1) / p_CHUNK;
  localparam int EW     = NCHUNK * p_CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [EW-1:0] x_q, x_d, y_q, y_d;
  logic [EW-1:0] x_ld, y_ld;
  logic          nz_q, nz_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    res_q, res_d;
  logic [p_CHUNK-1:0] xc, yc, xo;

`ifdef CMP_LGEZ_SEQ_SIGNED_EN
  // m_q marks bits flipped at load (bias + pad) so nz can see the original value
  logic [EW-1:0] m_q, m_d, m_ld;

  always_comb begin
    x_ld = EW'(i_x);
    y_ld = EW'(i_y);
    m_ld = '0;
    if (i_signed) begin
      for (int b = p_WIDTH; b < EW; b++) begin
        x_ld[b] = i_x[p_WIDTH-1];
        y_ld[b] = i_y[p_WIDTH-1];
      end
      for (int b = p_WIDTH - 1; b < EW; b++) m_ld[b] = 1'b1;
      x_ld = x_ld ^ m_ld;
      y_ld = y_ld ^ m_ld;
    end
  end

  assign xo = xc ^ m_q[EW-1 -: p_CHUNK];
`else
  assign x_ld = EW'(i_x);
  assign y_ld = EW'(i_y);
  assign xo   = xc;
`endif

  assign xc = x_q[EW-1 -: p_CHUNK];
  assign yc = y_q[EW-1 -: p_CHUNK];

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    nz_d    = nz_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
`ifdef CMP_LGEZ_SEQ_SIGNED_EN
    m_d     = m_q;
`endif
    case (state_q)
      S_IDLE: if (i_valid) begin
        state_d = S_SCAN;
        x_d     = x_ld;
        y_d     = y_ld;
        nz_d    = 1'b0;
        cnt_d   = '0;
`ifdef CMP_LGEZ_SEQ_SIGNED_EN
        m_d     = m_ld;
`endif
      end
      S_SCAN: begin
        if (xc > yc) begin
          res_d   = 2'b10;
          state_d = S_DONE;
        end else if (xc < yc) begin
          res_d   = 2'b01;
          state_d = S_DONE;
        end else begin
          nz_d = nz_q | (|xo);
          x_d  = x_q << p_CHUNK;
          y_d  = y_q << p_CHUNK;
`ifdef CMP_LGEZ_SEQ_SIGNED_EN
          m_d  = m_q << p_CHUNK;
`endif
          if (cnt_q == LAST) begin
            res_d   = (nz_q | (|xo)) ? 2'b11 : 2'b00;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DONE: if (o_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      nz_q    <= 1'b0;
      cnt_q   <= '0;
      res_q   <= 2'b00;
`ifdef CMP_LGEZ_SEQ_SIGNED_EN
      m_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      nz_q    <= nz_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
`ifdef CMP_LGEZ_SEQ_SIGNED_EN
      m_q     <= m_d;
`endif
    end
  end

  assign i_ready = (state_q == S_IDLE);
  assign o_busy  = (state_q == S_SCAN);
  assign o_valid = (state_q == S_DONE);
  assign o_res   = res_q;

endmodule

// File: tb/tb_cmp_lgez_seq.sv
// Self-checking bench for cmp_lgez_seq (p_WIDTH=8, p_CHUNK=2): directed, random, backpressure, reset.
module tb_cmp_lgez_seq;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_valid = 1'b0;
  logic       i_ready;
  logic [7:0] i_x = '0, i_y = '0;
  logic       o_valid, o_ready = 1'b1, o_busy;
  logic [1:0] o_res;
`ifdef CMP_LGEZ_SEQ_SIGNED_EN
  logic       i_signed = 1'b0;
`endif
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  cmp_lgez_seq #(.p_WIDTH(8), .p_CHUNK(2)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(i_ready),
    .i_x(i_x), .i_y(i_y),
`ifdef CMP_LGEZ_SEQ_SIGNED_EN
    .i_signed(i_signed),
`endif
    .o_valid(o_valid), .o_ready(o_ready), .o_res(o_res), .o_busy(o_busy)
  );

  // Reference: ordering from integer compare, latency from first differing 2-bit prefix.
  function automatic void model(input logic [7:0] x, input logic [7:0] y, input bit sgn,
                                output logic [1:0] r, output int lat);
    logic [7:0] xb, yb;
    if (sgn) r = ($signed(x) > $signed(y)) ? 2'b10 : ($signed(x) < $signed(y)) ? 2'b01 : 2'b00;
    else     r = (x > y) ? 2'b10 : (x < y) ? 2'b01 : 2'b00;
    if (x == y) r = (x == 8'd0) ? 2'b00 : 2'b11;
    xb = sgn ? (x ^ 8'h80) : x;
    yb = sgn ? (y ^ 8'h80) : y;
    lat = 4;
    for (int k = 1; k <= 4; k++)
      if ((xb >> (8 - 2*k)) != (yb >> (8 - 2*k))) begin lat = k; break; end
  endfunction

  // Drive one accept; return result, edges to o_valid, timeout flag and busy/ready sanity during scan.
  task automatic do_txn(input logic [7:0] x, input logic [7:0] y, output logic [1:0] res,
                        output int lat, output bit to, output bit busy_ok);
    @(negedge clk);
    i_valid = 1'b1; i_x = x; i_y = y;
    @(posedge clk); #1;
    i_valid = 1'b0;
    lat = 0; to = 0; busy_ok = 1;
    while (!o_valid) begin
      if (!(o_busy === 1'b1 && i_ready === 1'b0)) busy_ok = 0;
      @(posedge clk); #1;
      lat++;
      if (lat > 20) begin to = 1; break; end
    end
    res = o_res;
  endtask

  task automatic test_reset;
    #1;
    total++; if (i_ready !== 1'b1) begin bad++; $display("FAIL reset_i_ready act=%b exp=1", i_ready); end
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_o_valid act=%b exp=0", o_valid); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_o_busy act=%b exp=0", o_busy); end
    total++; if (o_res !== 2'b00) begin bad++; $display("FAIL reset_o_res act=%b exp=00", o_res); end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_directed;
    logic [7:0] tx [6] = '{8'h00, 8'hA5, 8'h01, 8'h80, 8'h12, 8'h20};
    logic [7:0] ty [6] = '{8'h00, 8'hA5, 8'h01, 8'h7F, 8'h13, 8'h10};
    logic [1:0] tr [6] = '{2'b00, 2'b11, 2'b11, 2'b10, 2'b01, 2'b10};
    int         tl [6] = '{4, 4, 4, 1, 4, 2};
    logic [1:0] r; int lat; bit to, bok;
    o_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      do_txn(tx[i], ty[i], r, lat, to, bok);
      total++; if (to) begin bad++; $display("FAIL dir_timeout[%0d] no o_valid", i); end
      total++; if (r !== tr[i]) begin bad++; $display("FAIL dir_res[%0d] act=%b exp=%b", i, r, tr[i]); end
      total++; if (lat != tl[i]) begin bad++; $display("FAIL dir_lat[%0d] act=%0d exp=%0d", i, lat, tl[i]); end
      total++; if (!bok) begin bad++; $display("FAIL dir_busy[%0d] busy/ready wrong during scan", i); end
      @(posedge clk); #1;
      total++; if (o_valid !== 1'b0 || i_ready !== 1'b1 || o_res !== tr[i]) begin
        bad++; $display("FAIL dir_release[%0d] o_valid=%b i_ready=%b o_res=%b exp 0/1/%b",
                        i, o_valid, i_ready, o_res, tr[i]);
      end
    end
  endtask

  task automatic test_random;
    logic [7:0] x, y; logic [1:0] r, er; int lat, el; bit to, bok;
    int nbad = 0;
    o_ready = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      x = 8'($urandom);
      y = (i % 4 == 0) ? x : (i % 4 == 1) ? (x ^ 8'(1 << $urandom_range(7, 0))) : 8'($urandom);
      model(x, y, 1'b0, er, el);
      do_txn(x, y, r, lat, to, bok);
      total++;
      if (to || r !== er || lat != el || !bok) begin
        bad++; nbad++;
        if (nbad < 10) $display("FAIL rnd x=%h y=%h res=%b lat=%0d exp res=%b lat=%0d to=%0d busy_ok=%0d",
                                x, y, r, lat, er, el, to, bok);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure;
    logic [1:0] r; int lat; bit to, bok;
    o_ready = 1'b0;
    do_txn(8'd3, 8'd5, r, lat, to, bok);
    total++; if (to || r !== 2'b01 || lat != 3) begin
      bad++; $display("FAIL bp_first res=%b lat=%0d exp res=01 lat=3", r, lat);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      i_valid = i[0]; i_x = 8'($urandom); i_y = 8'($urandom);
      @(posedge clk); #1;
      total++; if (o_valid !== 1'b1 || o_res !== 2'b01 || i_ready !== 1'b0 || o_busy !== 1'b0) begin
        bad++; $display("FAIL bp_hold[%0d] o_valid=%b o_res=%b i_ready=%b o_busy=%b exp 1/01/0/0",
                        i, o_valid, o_res, i_ready, o_busy);
      end
    end
    @(negedge clk); i_valid = 1'b0; o_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (o_valid !== 1'b0 || i_ready !== 1'b1) begin
      bad++; $display("FAIL bp_release o_valid=%b i_ready=%b exp 0/1", o_valid, i_ready);
    end
    @(posedge clk); #1;
    total++; if (o_busy !== 1'b0 || i_ready !== 1'b1) begin
      bad++; $display("FAIL bp_no_capture o_busy=%b i_ready=%b exp 0/1", o_busy, i_ready);
    end
  endtask

  task automatic test_reset_midscan;
    bit seen = 0;
    o_ready = 1'b1;
    @(negedge clk); i_valid = 1'b1; i_x = 8'h00; i_y = 8'h00;
    @(posedge clk); #1; i_valid = 1'b0;
    @(posedge clk); #2;
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL mid_busy act=%b exp=1", o_busy); end
    rst_n = 1'b0; #1;
    total++; if (o_valid !== 1'b0 || o_busy !== 1'b0 || i_ready !== 1'b1 || o_res !== 2'b00) begin
      bad++; $display("FAIL mid_reset o_valid=%b o_busy=%b i_ready=%b o_res=%b exp 0/0/1/00",
                      o_valid, o_busy, i_ready, o_res);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin @(posedge clk); #1; if (o_valid !== 1'b0) seen = 1; end
    total++; if (seen) begin bad++; $display("FAIL mid_no_pulse act=1 exp=0"); end
  endtask

`ifdef CMP_LGEZ_SEQ_SIGNED_EN
  task automatic test_signed;
    logic [7:0] x, y; logic [1:0] r, er; int lat, el; bit to, bok;
    o_ready = 1'b1; i_signed = 1'b1;
    for (int i = 0; i < 300; i++) begin
      x = (i == 0) ? 8'h80 : 8'($urandom);
      y = (i == 0) ? 8'h7F : (i % 3 == 0) ? x : 8'($urandom);
      model(x, y, 1'b1, er, el);
      do_txn(x, y, r, lat, to, bok);
      total++;
      if (to || r !== er || lat != el) begin
        bad++; $display("FAIL sgn x=%h y=%h res=%b lat=%0d exp res=%b lat=%0d", x, y, r, lat, er, el);
      end
      @(posedge clk); #1;
    end
    i_signed = 1'b0;
  endtask
`endif

  initial begin
    test_reset;
    test_directed;
    test_backpressure;
    test_random;
`ifdef CMP_LGEZ_SEQ_SIGNED_EN
    test_signed;
`endif
    test_reset_midscan;
    test_directed;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
